// File: rtl/ltc_frame_align.sv
// ltc_frame_align
//   Frame-alignment controller for the LTC ADC LVDS receiver, running in the
//   sample clock domain beside the deserializer. It pulses bitslip until the
//   deserialized frame-clock word equals FRAME_PATTERN, declares lock, and
//   keeps watching so that a sustained loss of frame triggers re-alignment.
//
// Ports
//   sample_clk  in   1  sample clock, rising edge
//   sample_rst  in   1  synchronous active-high reset, overrides enable
//   enable      in   1  level: 1 runs alignment, 0 returns to IDLE
//   frame_word  in   8  deserialized frame-clock word, one per cycle
//   bitslip     out  1  single-cycle pulse to the deserializer bitslip input
//   locked      out  1  frame aligned
//   fail        out  1  MAX_SLIPS exhausted without lock
//   slip_count  out  4  bitslips since the last (re)start of alignment
//   lost_count  out  8  loss-of-lock events, saturating at 255
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | disabled; outputs cleared except lost_count
// SETTLE | down-counting while the deserializer pipeline flushes
// CHECK  | comparing frame_word, counting consecutive matches
// SLIP   | issuing one bitslip pulse
// LOCKED | aligned; counting consecutive misses for loss detection
// FAIL   | slips exhausted; held until enable drops

module ltc_frame_align #(
    parameter logic [7:0] FRAME_PATTERN = 8'hF0,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         CHECK_CYCLES  = 8,
    parameter int         MAX_SLIPS     = 8,
    parameter int         LOSS_THRESH   = 4
) (
    input  logic       sample_clk,
    input  logic       sample_rst,
    input  logic       enable,
    input  logic [7:0] frame_word,
    output logic       bitslip,
    output logic       locked,
    output logic       fail,
    output logic [3:0] slip_count,
    output logic [7:0] lost_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_SLIP   = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    // The settle counter is loaded with SETTLE_CYCLES and leaves SETTLE one
    // edge after reaching zero, so SETTLE spans SETTLE_CYCLES+1 edges in total.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] MATCH_LAST  = 8'(CHECK_CYCLES - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);
    localparam logic [7:0] MISS_LIMIT  = 8'(LOSS_THRESH);

    logic [2:0] state;
    logic [7:0] settle_cnt;
    logic [7:0] match_cnt;
    logic [7:0] miss_cnt;
    logic       word_match;

    assign word_match = (frame_word == FRAME_PATTERN);

    always_ff @(posedge sample_clk) begin
        if (sample_rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            slip_count <= '0;
            lost_count <= '0;
        end else begin
            bitslip <= 1'b0;
            if (!enable) begin
                state      <= ST_IDLE;
                settle_cnt <= '0;
                match_cnt  <= '0;
                miss_cnt   <= '0;
                locked     <= 1'b0;
                fail       <= 1'b0;
                slip_count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        locked     <= 1'b0;
                        fail       <= 1'b0;
                        slip_count <= '0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == 8'd0) begin
                            match_cnt <= '0;
                            state     <= ST_CHECK;
                        end else begin
                            settle_cnt <= settle_cnt - 8'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (word_match) begin
                            if (match_cnt == MATCH_LAST) begin
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                                state    <= ST_LOCKED;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else if (slip_count == SLIP_MAX) begin
                            state <= ST_FAIL;
                        end else begin
                            state <= ST_SLIP;
                        end
                    end
                    ST_SLIP: begin
                        bitslip    <= 1'b1;
                        slip_count <= slip_count + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= ST_SETTLE;
                    end
                    ST_LOCKED: begin
                        // The miss counter reaching the limit is acted on one
                        // edge later, independent of the word then present.
                        if (miss_cnt == MISS_LIMIT) begin
                            locked     <= 1'b0;
                            slip_count <= '0;
                            miss_cnt   <= '0;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= ST_SETTLE;
                            if (lost_count != 8'hFF) begin
                                lost_count <= lost_count + 8'd1;
                            end
                        end else if (word_match) begin
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end
                    ST_FAIL: begin
                        fail <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ltc_frame_align.sv
// Directed bench for ltc_frame_align with default parameters.
// A small deserializer model rotates frame_word left on each bitslip pulse
// when rot_en is set.

module tb_ltc_frame_align;

    logic       sample_clk;
    logic       sample_rst;
    logic       enable;
    logic [7:0] frame_word;
    logic       bitslip;
    logic       locked;
    logic       fail;
    logic [3:0] slip_count;
    logic [7:0] lost_count;

    int tests_run   = 0;
    int tests_fail  = 0;
    int cyc         = 0;
    int pulses      = 0;
    int last_pulse  = -1;
    int exp_lost    = 0;
    int n;
    bit rot_en      = 1'b0;

    ltc_frame_align dut (
        .sample_clk (sample_clk),
        .sample_rst (sample_rst),
        .enable     (enable),
        .frame_word (frame_word),
        .bitslip    (bitslip),
        .locked     (locked),
        .fail       (fail),
        .slip_count (slip_count),
        .lost_count (lost_count)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, then run the deserializer model.
    task automatic tick();
        @(posedge sample_clk);
        #1;
        cyc++;
        if (bitslip === 1'b1) begin
            pulses++;
            if (last_pulse >= 0)
                chk("bitslip_gap_ge_17", 32'((cyc - last_pulse) >= 17), 32'd1);
            last_pulse = cyc;
            if (rot_en) frame_word = {frame_word[6:0], frame_word[7]};
        end
    endtask

    task automatic new_test();
        pulses     = 0;
        last_pulse = -1;
    endtask

    // SETTLE was loaded at the edge just taken: lock lands 25 edges later.
    task automatic expect_lock_in_25(input string tag);
        repeat (24) tick();
        chk({tag, "_not_early"}, 32'(locked), 32'd0);
        tick();
        chk({tag, "_locked"}, 32'(locked), 32'd1);
        chk({tag, "_slip_count"}, 32'(slip_count), 32'd0);
    endtask

    task automatic wait_locked(input int budget, input string tag);
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_lock_timeout"}, 32'(locked), 32'd1);
    endtask

    task automatic lose_lock(input string tag);
        frame_word = 8'hAA;
        repeat (4) tick();
        chk({tag, "_hold_at_4th_miss"}, 32'(locked), 32'd1);
        frame_word = 8'hF0;
        tick();
        exp_lost++;
        chk({tag, "_dropped"}, 32'(locked), 32'd0);
        chk({tag, "_lost_count"}, 32'(lost_count), 32'(exp_lost));
        expect_lock_in_25({tag, "_relock"});
        chk({tag, "_lost_kept"}, 32'(lost_count), 32'(exp_lost));
    endtask

    initial begin
        sample_rst = 1'b1;
        enable     = 1'b0;
        frame_word = 8'hF0;
        repeat (2) tick();
        chk("rst_bitslip", 32'(bitslip), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_slip_count", 32'(slip_count), 32'd0);
        chk("rst_lost_count", 32'(lost_count), 32'd0);
        sample_rst = 1'b0;
        tick();

        // Aligned start
        new_test();
        enable = 1'b1;
        tick();
        expect_lock_in_25("aligned");
        chk("aligned_no_bitslip", 32'(pulses), 32'd0);

        // Glitch tolerance: 3 misses then a match keeps lock
        frame_word = 8'hAA;
        repeat (3) tick();
        frame_word = 8'hF0;
        tick();
        chk("glitch3_locked", 32'(locked), 32'd1);
        repeat (2) tick();
        chk("glitch3_still_locked", 32'(locked), 32'd1);
        lose_lock("loss1");
        chk("loss1_no_bitslip", 32'(pulses), 32'd0);

        // Misaligned by 3 slips
        enable = 1'b0;
        tick();
        chk("dis_slip_count", 32'(slip_count), 32'd0);
        chk("dis_lost_kept", 32'(lost_count), 32'd1);
        new_test();
        rot_en     = 1'b1;
        frame_word = 8'h1E;
        enable     = 1'b1;
        wait_locked(400, "mis3");
        chk("mis3_pulses", 32'(pulses), 32'd3);
        chk("mis3_slip_count", 32'(slip_count), 32'd3);
        chk("mis3_frame", 32'(frame_word), 32'hF0);

        // Never matches
        enable = 1'b0;
        tick();
        chk("dis2_slip_count", 32'(slip_count), 32'd0);
        new_test();
        rot_en     = 1'b0;
        frame_word = 8'hAA;
        enable     = 1'b1;
        n = 0;
        while (fail !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("nomatch_fail", 32'(fail), 32'd1);
        chk("nomatch_pulses", 32'(pulses), 32'd8);
        chk("nomatch_locked", 32'(locked), 32'd0);
        chk("nomatch_slip_count", 32'(slip_count), 32'd8);
        repeat (5) tick();
        chk("nomatch_fail_held", 32'(fail), 32'd1);
        chk("nomatch_no_extra_slip", 32'(pulses), 32'd8);
        enable = 1'b0;
        tick();
        chk("nomatch_dis_fail", 32'(fail), 32'd0);
        chk("nomatch_dis_slip_count", 32'(slip_count), 32'd0);

        // enable dropped mid-CHECK after 2 slips
        new_test();
        rot_en     = 1'b1;
        frame_word = 8'h3C;
        enable     = 1'b1;
        n = 0;
        while (pulses < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("midchk_two_pulses", 32'(pulses), 32'd2);
        repeat (20) tick();
        chk("midchk_not_locked", 32'(locked), 32'd0);
        chk("midchk_slip_count", 32'(slip_count), 32'd2);
        enable = 1'b0;
        tick();
        chk("midchk_dis_slip_count", 32'(slip_count), 32'd0);
        chk("midchk_dis_locked", 32'(locked), 32'd0);
        chk("midchk_dis_lost_kept", 32'(lost_count), 32'd1);
        rot_en     = 1'b0;
        frame_word = 8'hF0;
        enable     = 1'b1;
        tick();
        expect_lock_in_25("reenable");
        chk("reenable_pulses", 32'(pulses), 32'd2);

        // Build lost_count up to 5, then reset while locked
        for (int i = 0; i < 4; i++) lose_lock("lossN");
        chk("pre_rst_locked", 32'(locked), 32'd1);
        chk("pre_rst_lost", 32'(lost_count), 32'd5);
        sample_rst = 1'b1;
        tick();
        chk("rst2_bitslip", 32'(bitslip), 32'd0);
        chk("rst2_locked", 32'(locked), 32'd0);
        chk("rst2_fail", 32'(fail), 32'd0);
        chk("rst2_slip_count", 32'(slip_count), 32'd0);
        chk("rst2_lost_count", 32'(lost_count), 32'd0);
        sample_rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule

// File: doc/ltc_frame_align.md
# ltc_frame_align

Frame-alignment controller for the LTC ADC LVDS receiver. It runs in the sample clock domain next to the deserializer and watches the 8-bit deserialized frame-clock word. It issues single-cycle bitslip pulses until that word equals the expected frame pattern, then declares lock. It keeps monitoring after lock and re-aligns on sustained loss of frame, counting each loss event for CSR readout.

## Interface
Parameters:
- FRAME_PATTERN, 8'hF0, expected deserialized frame word when aligned
- SETTLE_CYCLES, 16, wait after enable or after each bitslip before comparing (deserializer pipeline flush); range 1..255
- CHECK_CYCLES, 8, consecutive matching words required to declare lock; range 1..255
- MAX_SLIPS, 8, bitslips attempted before declaring failure; range 1..15
- LOSS_THRESH, 4, consecutive mismatches while locked that declare loss of lock; range 1..255

Ports (one clock; reset is synchronous and active-high):
- sample_clk  in  1  sample clock; all logic is on its rising edge
- sample_rst  in  1  synchronous, active-high reset
- enable  in  1  level; 1 runs alignment, 0 returns the block to IDLE
- frame_word  in  8  deserialized frame-clock word, one per cycle
- bitslip  out  1  single-cycle pulse to the deserializer bitslip input
- locked  out  1  frame aligned
- fail  out  1  MAX_SLIPS exhausted without lock
- slip_count  out  4  bitslips issued since the last (re)start of alignment
- lost_count  out  8  loss-of-lock events, saturating

## Operation
- FSM states: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- IDLE: all outputs 0 except lost_count. slip_count is cleared. If enable=1, go to SETTLE and load the settle counter.
- SETTLE: count SETTLE_CYCLES cycles without comparing, then go to CHECK with the match counter at 0.
- CHECK: compare frame_word to FRAME_PATTERN every cycle.
  - On a match, increment the match counter. On the CHECK_CYCLES-th consecutive match, go to LOCKED.
  - On any mismatch: if slip_count == MAX_SLIPS, go to FAIL; otherwise go to SLIP.
- SLIP: one cycle. The bitslip register is set, so bitslip is high during the next cycle only. slip_count increments. Next state is SETTLE.
- LOCKED: locked=1. A match clears the miss counter; a mismatch increments it.
  - When the miss counter reaches LOSS_THRESH: locked drops, lost_count increments (saturates at 255), slip_count is cleared, and the FSM goes to SETTLE.
  - Sporadic mismatches below LOSS_THRESH never drop locked.
- FAIL: fail=1 and slip_count holds its value. The block leaves FAIL only when enable goes 0, then returns to IDLE.
- enable=0 in any state forces IDLE on the next edge. That edge clears locked, fail, bitslip and slip_count; lost_count is kept.
- sample_rst forces IDLE and clears every output and counter, including lost_count. It takes priority over enable.
- Bitslips are never back-to-back: consecutive pulses are separated by at least SETTLE_CYCLES+1 cycles.

## Timing
- All outputs are registered. Reset values: bitslip=0, locked=0, fail=0, slip_count=0, lost_count=0.
- Already-aligned input: enable is first sampled high at edge E. locked rises at edge E+1+SETTLE_CYCLES+CHECK_CYCLES. With defaults that is E+25.
- Per bitslip: the mismatch is sampled at edge M, and bitslip is high from edge M+1 to M+2. The FSM re-enters CHECK at edge M+2+SETTLE_CYCLES.
- Loss of lock: the LOSS_THRESH-th consecutive mismatch is sampled at edge L. At edge L+1, locked=0 and lost_count has incremented.
- FAIL: fail rises one edge after the mismatch that is sampled in CHECK with slip_count == MAX_SLIPS.
- A mismatch on the last required CHECK cycle counts as a mismatch; lock is not declared.

## Test plan
- Aligned start: frame_word fixed at 8'hF0, enable raised -> bitslip never pulses, locked=1 exactly 25 cycles after enable, slip_count=0.
- Misaligned by 3 slips: a model rotates frame_word left one bit per bitslip pulse, starting from 8'h1E -> exactly 3 single-cycle bitslip pulses, each separated by at least 17 cycles; locked=1 with slip_count=3.
- Never matches: frame_word fixed at 8'hAA -> 8 bitslip pulses, then fail=1, locked=0, slip_count=8. Dropping enable returns fail=0 and slip_count=0 one cycle later.
- Glitch tolerance and loss:
  - While locked, inject 3 consecutive mismatches -> locked stays 1.
  - Then inject 4 consecutive mismatches -> locked drops, lost_count=1, realignment restarts. The frame restored to 8'hF0 -> locked again, with lost_count still 1.
- enable dropped mid-CHECK after 2 slips -> IDLE on the next edge with slip_count=0. Re-enable restarts from SETTLE.
- sample_rst asserted while locked with lost_count=5 -> on the next edge every output is 0, including lost_count.
